// File: rtl/clock_pkg.sv
// Shared calendar definitions for the century clock: field widths, month
// constants and the days-per-month lookup.
package clock_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;

  localparam logic [MONTH_W-1:0] JAN = 4'd1;
  localparam logic [MONTH_W-1:0] FEB = 4'd2;
  localparam logic [MONTH_W-1:0] MAR = 4'd3;
  localparam logic [MONTH_W-1:0] APR = 4'd4;
  localparam logic [MONTH_W-1:0] MAY = 4'd5;
  localparam logic [MONTH_W-1:0] JUN = 4'd6;
  localparam logic [MONTH_W-1:0] JUL = 4'd7;
  localparam logic [MONTH_W-1:0] AUG = 4'd8;
  localparam logic [MONTH_W-1:0] SEP = 4'd9;
  localparam logic [MONTH_W-1:0] OCT = 4'd10;
  localparam logic [MONTH_W-1:0] NOV = 4'd11;
  localparam logic [MONTH_W-1:0] DEC = 4'd12;

  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                     input logic leap);
    case (month)
      FEB:                days_in_month = leap ? 5'd29 : 5'd28;
      APR, JUN, SEP, NOV: days_in_month = 5'd30;
      default:            days_in_month = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/leap_year_detect.sv
// Combinational Gregorian leap-year test on the current year value.
module leap_year_detect #(
  parameter int YEAR_W = 16
) (
  input  logic [YEAR_W-1:0] year,
  output logic              leap
);

  localparam logic [YEAR_W-1:0] Y4   = YEAR_W'(4);
  localparam logic [YEAR_W-1:0] Y100 = YEAR_W'(100);
  localparam logic [YEAR_W-1:0] Y400 = YEAR_W'(400);

  logic div4, div100, div400;

  assign div4   = (year % Y4)   == '0;
  assign div100 = (year % Y100) == '0;
  assign div400 = (year % Y400) == '0;
  assign leap   = div4 && (!div100 || div400);

endmodule

// File: rtl/date_counter.sv
// Day/month calendar stage: advances the date on day carries and front-panel
// set pulses, and emits a one-cycle year carry on the 31 Dec rollover.
module date_counter
  import clock_pkg::*;
#(
  parameter int YEAR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              count_day,
  input  logic              set_day,
  input  logic              set_month,
  input  logic [YEAR_W-1:0] year,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic              count_year
);

  logic                 leap_now;
  logic                 leap_q;
  logic [DAY_W-1:0]     dim;
  logic [DAY_W-1:0]     dim_inc;
  logic [MONTH_W-1:0]   month_inc;
  logic [DAY_W-1:0]     day_next;
  logic [MONTH_W-1:0]   month_next;
  logic                 count_year_next;

  leap_year_detect #(
    .YEAR_W (YEAR_W)
  ) u_leap (
    .year (year),
    .leap (leap_now)
  );

  // Next-state mux; priority is count_day, then set_month, then set_day.
  always_comb begin
    dim             = days_in_month(month, leap_q);
    month_inc       = (month >= DEC) ? JAN : month + 4'd1;
    dim_inc         = days_in_month(month_inc, leap_q);
    day_next        = day;
    month_next      = month;
    count_year_next = 1'b0;

    if (month == 4'd0 || month > DEC) begin
      month_next = JAN;
    end else if (count_day) begin
      if (day >= dim) begin
        day_next        = 5'd1;
        month_next      = month_inc;
        count_year_next = (month == DEC);
      end else begin
        day_next = day + 5'd1;
      end
    end else if (set_month) begin
      month_next = month_inc;
      day_next   = (day > dim_inc) ? dim_inc : day;
    end else if (set_day) begin
      day_next = (day >= dim) ? 5'd1 : day + 5'd1;
    end else if (day > dim) begin
      // A year change can invalidate 29 Feb once leap_q drops.
      day_next = dim;
    end else if (day == 5'd0) begin
      day_next = 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leap_q     <= 1'b1;
      day        <= 5'd1;
      month      <= JAN;
      count_year <= 1'b0;
    end else begin
      leap_q     <= leap_now;
      day        <= day_next;
      month      <= month_next;
      count_year <= count_year_next;
    end
  end

endmodule
